// File: rtl/hs_elastic_fifo_pkg.sv
// rtl/hs_elastic_fifo_pkg.sv - shared helpers and handshake timing constants
package hs_elastic_fifo_pkg;

  // Minimum idle cycles on a req line between two request episodes.
  localparam int HS_GAP = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// rtl/hs_fifo_mem.sv - register array, synchronous write port and registered read port
module hs_fifo_mem
  import hs_elastic_fifo_pkg::*;
#(
  parameter int data_width = 32,
  parameter int depth      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [clog2(depth)-1:0]   waddr,
  input  logic [data_width-1:0]     wdata,
  input  logic                      re,
  input  logic [clog2(depth)-1:0]   raddr,
  output logic [data_width-1:0]     rdata
);

  logic [data_width-1:0] mem [depth];

  // Storage is not reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/hs_elastic_fifo.sv
// rtl/hs_elastic_fifo.sv - req/ack elastic buffer: pulls from upstream, serves downstream
module hs_elastic_fifo
  import hs_elastic_fifo_pkg::*;
#(
  parameter int data_width = 32,
  parameter int depth      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    req_l,
  input  logic                    ack_l,
  input  logic [data_width-1:0]   din,
  input  logic                    req_r,
  output logic                    ack_r,
  output logic [data_width-1:0]   dout,
  output logic [clog2(depth):0]   level,
  output logic                    err
);

  localparam int ptr_width = clog2(depth);
  localparam logic [ptr_width:0]   lvl_full = (ptr_width + 1)'(depth);
  localparam logic [ptr_width:0]   lvl_one  = (ptr_width + 1)'(1);
  localparam logic [ptr_width-1:0] ptr_one  = ptr_width'(1);

  logic [ptr_width-1:0] wr_ptr;
  logic [ptr_width-1:0] rd_ptr;
  logic                 wr_fire;
  logic                 rd_fire;

  assign wr_fire = ack_l & req_l;
  // Uses the registered level, so a read never targets the entry being written.
  assign rd_fire = req_r & ~ack_r & (level != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      req_l  <= 1'b0;
      ack_r  <= 1'b0;
      level  <= '0;
      err    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      ack_r <= rd_fire;
      if (wr_fire) begin
        req_l  <= 1'b0;
        wr_ptr <= wr_ptr + ptr_one;
      end else if (!req_l && !ack_l && level < lvl_full) begin
        req_l <= 1'b1;
      end
      if (rd_fire) rd_ptr <= rd_ptr + ptr_one;
      if (ack_l && !req_l) err <= 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   level <= level + lvl_one;
        2'b01:   level <= level - lvl_one;
        default: level <= level;
      endcase
    end
  end

  hs_fifo_mem #(
    .data_width(data_width),
    .depth     (depth)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_fire),
    .waddr(wr_ptr),
    .wdata(din),
    .re   (rd_fire),
    .raddr(rd_ptr),
    .rdata(dout)
  );

endmodule
